// File: rtl/hdmi_timing_gen.sv
// Video timing generator with a two-stage pixel output pipeline for the TMDS transmit path.
// Three preset modes plus a programmable custom mode; the active timing set only changes on frame boundaries.
module hdmi_timing_gen #(
    parameter int CW    = 8,
    parameter int CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic [3*CW-1:0]  pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             hsync,
    output logic             vsync,
    output logic             ve,
    output logic             frame_start,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             underflow,
    input  logic             underflow_clr,
    output logic             fsm_state
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] htr;
        logic [CNT_W-1:0] hsr;
        logic [CNT_W-1:0] hbpr;
        logic [CNT_W-1:0] hfpr;
        logic [CNT_W-1:0] vtr;
        logic [CNT_W-1:0] vsr;
        logic [CNT_W-1:0] vbpr;
        logic [CNT_W-1:0] vfpr;
        logic             pol;
    } timing_t;

    typedef struct packed {
        logic            ve;
        logic            hs;
        logic            vs;
        logic            fs;
        logic [3*CW-1:0] pix;
    } stage_t;

    function automatic timing_t mk_timing(input int ht, input int hs, input int hb, input int hf,
                                          input int vt, input int vs, input int vb, input int vf,
                                          input logic p);
        timing_t t;
        t.htr  = CNT_W'(ht);
        t.hsr  = CNT_W'(hs);
        t.hbpr = CNT_W'(hb);
        t.hfpr = CNT_W'(hf);
        t.vtr  = CNT_W'(vt);
        t.vsr  = CNT_W'(vs);
        t.vbpr = CNT_W'(vb);
        t.vfpr = CNT_W'(vf);
        t.pol  = p;
        return t;
    endfunction

    state_t           state, state_next;
    logic             run;
    timing_t          act, cust, next_set;
    logic [CNT_W-1:0] hcnt, vcnt, h_last, v_last;
    logic             h_wrap, frame_end, load;
    logic             active_raw;
    stage_t           raw, idle, s1, s2;

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state; start low forces IDLE from anywhere, mid-frame included
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run       = (state == RUN);
        fsm_state = state;
    end

    always_comb begin
        next_set = cust;
        case (mode)
            2'b00:   next_set = mk_timing(800, 96, 144, 784, 525, 2, 35, 515, 1'b0);
            2'b01:   next_set = mk_timing(1056, 128, 216, 1016, 628, 4, 27, 627, 1'b1);
            2'b10:   next_set = mk_timing(1650, 40, 260, 1540, 750, 5, 25, 745, 1'b1);
            default: next_set = cust;
        endcase
    end

    // A programmed total of 0 behaves as 1, so the last position clamps to 0.
    assign h_last    = (act.htr == '0) ? '0 : act.htr - CNT_W'(1);
    assign v_last    = (act.vtr == '0) ? '0 : act.vtr - CNT_W'(1);
    assign h_wrap    = (hcnt == h_last);
    assign frame_end = h_wrap && (vcnt == v_last);
    assign load      = (state == IDLE && start) || (state == RUN && frame_end);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cust <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                4'd0:    cust.htr  <= cfg_data;
                4'd1:    cust.hsr  <= cfg_data;
                4'd2:    cust.hbpr <= cfg_data;
                4'd3:    cust.hfpr <= cfg_data;
                4'd4:    cust.vtr  <= cfg_data;
                4'd5:    cust.vsr  <= cfg_data;
                4'd6:    cust.vbpr <= cfg_data;
                4'd7:    cust.vfpr <= cfg_data;
                4'd8:    cust.pol  <= cfg_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     act <= mk_timing(800, 96, 144, 784, 525, 2, 35, 515, 1'b0);
        else if (load) act <= next_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!start || state == IDLE) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= (vcnt == v_last) ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    assign hcount = hcnt;
    assign vcount = vcnt;

    // Handshake: pix_ready depends only on state and counters, never on pix_valid; a pixel
    // transfers on any rising edge where both are high, and ready without valid is an underflow.
    assign active_raw = (hcnt >= act.hbpr) && (hcnt < act.hfpr) &&
                        (vcnt >= act.vbpr) && (vcnt < act.vfpr);
    assign pix_ready  = run && active_raw;

    always_comb begin
        raw.ve  = pix_ready;
        raw.hs  = (run && hcnt < act.hsr) ? act.pol : ~act.pol;
        raw.vs  = (run && vcnt < act.vsr) ? act.pol : ~act.pol;
        raw.fs  = pix_ready && (hcnt == act.hbpr) && (vcnt == act.vbpr);
        raw.pix = (pix_ready && pix_valid) ? pix_data : '0;
        idle     = '0;
        idle.hs  = ~act.pol;
        idle.vs  = ~act.pol;
    end

    // Dropping start flushes both stages so outputs go idle on the very next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else if (!start) begin
            s1 <= idle;
            s2 <= idle;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign {red, green, blue} = s2.pix;
    assign hsync       = s2.hs;
    assign vsync       = s2.vs;
    assign ve          = s2.ve;
    assign frame_start = s2.fs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      underflow <= 1'b0;
        else if (pix_ready && !pix_valid) underflow <= 1'b1;
        else if (underflow_clr)         underflow <= 1'b0;
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: randomized pixel source and control, checked against a
// frame-position reference model with a two-deep expected-output queue.
module tb_hdmi_timing_gen;

    localparam int CW    = 8;
    localparam int CNT_W = 12;
    localparam int W     = 3*CW + 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    logic [3*CW-1:0]  pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic [CW-1:0]    red, green, blue;
    logic             hsync, vsync, ve, frame_start;
    logic [CNT_W-1:0] hcount, vcount;
    logic             underflow;
    logic             underflow_clr;
    logic             fsm_state;

    hdmi_timing_gen #(.CW(CW), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .ve(ve), .frame_start(frame_start),
        .hcount(hcount), .vcount(vcount),
        .underflow(underflow), .underflow_clr(underflow_clr),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: timing sets as {htr,hsr,hbpr,hfpr,vtr,vsr,vbpr,vfpr,pol}
    int presets[3][9];
    int m_set[9];
    int m_cust[9];
    int m_n;
    logic m_run;
    logic m_und;
    int src_idx = 0;
    int exp_idx = 0;
    int valid_pct = 100;
    int clr_pct = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3*CW-1:0] src_pixel(input int idx);
        return 24'(idx * 7 + 1) ^ 24'h5A3C96;
    endfunction

    function automatic logic [W-1:0] idle_entry(input logic p);
        return {1'b0, ~p, ~p, 1'b0, {3*CW{1'b0}}};
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_n   = 0;
        m_und = 1'b0;
        m_set = presets[0];
        foreach (m_cust[i]) m_cust[i] = 0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic check_all_zero();
        check_eq("rst_rgb", {8'h0, red, green, blue}, 32'h0);
        check_eq("rst_sync", {30'h0, hsync, vsync}, 32'h0);
        check_eq("rst_ve_fs", {30'h0, ve, frame_start}, 32'h0);
        check_eq("rst_hcount", 32'(hcount), 32'h0);
        check_eq("rst_vcount", 32'(vcount), 32'h0);
        check_eq("rst_underflow", 32'(underflow), 32'h0);
        check_eq("rst_pix_ready", 32'(pix_ready), 32'h0);
        check_eq("rst_state", 32'(fsm_state), 32'h0);
    endtask

    // one pixel clock: drive, predict, advance, then compare delayed outputs
    task automatic cycle();
        int ht, vt, h, v;
        logic p, act, hs, vs, fs, frame_end, xfer;
        logic [W-1:0] e;
        pix_valid     = ($urandom_range(0, 99) < valid_pct);
        underflow_clr = ($urandom_range(0, 99) < clr_pct);
        pix_data      = src_pixel(src_idx);
        ht  = (m_set[0] == 0) ? 1 : m_set[0];
        vt  = (m_set[4] == 0) ? 1 : m_set[4];
        h   = m_run ? m_n % ht : 0;
        v   = m_run ? m_n / ht : 0;
        p   = (m_set[8] != 0);
        act = m_run && h >= m_set[2] && h < m_set[3] && v >= m_set[6] && v < m_set[7];
        hs  = (m_run && h < m_set[1]) ? p : ~p;
        vs  = (m_run && v < m_set[5]) ? p : ~p;
        fs  = act && h == m_set[2] && v == m_set[6];
        check_eq("hcount", 32'(hcount), 32'(h));
        check_eq("vcount", 32'(vcount), 32'(v));
        check_eq("pix_ready", 32'(pix_ready), 32'(act));
        check_eq("state", 32'(fsm_state), 32'(m_run));
        e = {act, hs, vs, fs, (act && pix_valid) ? src_pixel(exp_idx) : {3*CW{1'b0}}};
        if (act && pix_valid) exp_idx++;
        m_und = (act && !pix_valid) || (m_und && !underflow_clr);
        if (!start) begin
            foreach (exp_q[i]) exp_q[i] = idle_entry(p);
            e = idle_entry(p);
        end
        exp_q.push_back(e);
        frame_end = m_run && (m_n == ht * vt - 1);
        if ((!m_run && start) || frame_end) begin
            if (mode == 2'b11) m_set = m_cust;
            else               m_set = presets[mode];
        end
        if (start) begin
            m_n   = (m_run && !frame_end) ? m_n + 1 : 0;
            m_run = 1'b1;
        end else begin
            m_n   = 0;
            m_run = 1'b0;
        end
        if (cfg_we && cfg_addr <= 4'd8)
            m_cust[cfg_addr] = (cfg_addr == 4'd8) ? int'(cfg_data[0]) : int'(cfg_data);
        xfer = pix_ready && pix_valid;
        @(posedge clock);
        if (xfer) src_idx++;
        @(negedge clock);
        e = exp_q.pop_front();
        check_eq("ve", 32'(ve), 32'(e[W-1]));
        check_eq("hsync", 32'(hsync), 32'(e[W-2]));
        check_eq("vsync", 32'(vsync), 32'(e[W-3]));
        check_eq("frame_start", 32'(frame_start), 32'(e[W-4]));
        check_eq("rgb", {8'h0, red, green, blue}, {8'h0, e[3*CW-1:0]});
        check_eq("underflow", 32'(underflow), 32'(m_und));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_random_start(input int n);
        for (int i = 0; i < n; i++) begin
            start = ($urandom_range(0, 149) != 0);
            cycle();
        end
        start = 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input int data);
        cfg_addr = addr;
        cfg_data = CNT_W'(data);
        cfg_we   = 1'b1;
        cycle();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_set(input int t[9]);
        for (int i = 0; i < 9; i++) cfg_write(4'(i), t[i]);
        cfg_write(4'($urandom_range(9, 15)), int'($urandom_range(0, 4095)));
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 check_all_zero();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int t[9];
        int hf, hb, vf, vb;
        presets[0] = '{800, 96, 144, 784, 525, 2, 35, 515, 0};
        presets[1] = '{1056, 128, 216, 1016, 628, 4, 27, 627, 1};
        presets[2] = '{1650, 40, 260, 1540, 750, 5, 25, 745, 1};
        reset = 1'b1; start = 1'b0; mode = 2'b00; cfg_we = 1'b0; cfg_addr = '0;
        cfg_data = '0; pix_data = '0; pix_valid = 1'b0; underflow_clr = 1'b0;
        #1 check_all_zero();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // 640x480 through the first active line; a mid-frame mode change must not take effect
        run_cycles(3);
        start = 1'b1;
        run_cycles(1000);
        mode = 2'b10;
        run_cycles(27800);
        start = 1'b0;
        run_cycles(4);

        // custom 20x10 frame programmed while idle, then underflow with random valid and clear
        cfg_set('{20, 2, 4, 16, 10, 1, 2, 8, 0});
        mode = 2'b11; valid_pct = 80; clr_pct = 10;
        start = 1'b1;
        run_cycles(700);

        // switch to 720p mid-frame, short stop mid-line, then asynchronous reset mid-frame
        mode = 2'b10; valid_pct = 95;
        run_cycles(3500);
        start = 1'b0;
        run_cycles(1);
        start = 1'b1;
        run_cycles(300);
        async_reset();

        mode = 2'b01;
        run_cycles(2200);
        start = 1'b0;
        run_cycles(2);

        // zero custom registers behave as a one-cycle frame
        mode = 2'b11; start = 1'b1;
        run_cycles(20);

        // random custom timings, rewritten mid-frame with random stops
        valid_pct = 85; clr_pct = 15;
        for (int it = 0; it < 25; it++) begin
            t[0] = $urandom_range(4, 24);
            hf   = $urandom_range(3, t[0]);
            hb   = $urandom_range(2, hf - 1);
            t[1] = $urandom_range(1, hb - 1);
            t[2] = hb; t[3] = hf;
            t[4] = $urandom_range(3, 12);
            vf   = $urandom_range(3, t[4]);
            vb   = $urandom_range(2, vf - 1);
            t[5] = $urandom_range(1, vb - 1);
            t[6] = vb; t[7] = vf;
            t[8] = $urandom_range(0, 1);
            cfg_set(t);
            run_random_start($urandom_range(150, 500));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
